// File: rtl/arith_pipe_pkg.sv
// Shared widths, narrowing modes and signed range helpers
// for the handshaked arithmetic pipeline and later DSP blocks.
package arith_pipe_pkg;

    localparam int ARITH_WRAP = 0;
    localparam int ARITH_SAT  = 1;

    function automatic int sum_w(input int w);
        return w + 1;
    endfunction

    function automatic int diff_w(input int w);
        return w + 2;
    endfunction

    function automatic int prod_w(input int w);
        return 3 * w + 2;
    endfunction

    // Largest value representable in an ow-bit signed number.
    function automatic logic signed [63:0] s_max(input int ow);
        return (64'sd1 <<< (ow - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in an ow-bit signed number.
    function automatic logic signed [63:0] s_min(input int ow);
        return -(64'sd1 <<< (ow - 1));
    endfunction

endpackage

// File: rtl/arith_pipe_hs_if.sv
// Operand/result handshake bundle for arith_pipe_hs.
// master: operand source + result sink; slave: the pipeline.
interface arith_pipe_hs_if #(
    parameter int W     = 9,
    parameter int OUT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [W-1:0]            a;
    logic [W-1:0]            b;
    logic [W-1:0]            c;
    logic [W-1:0]            d;
    logic [W-1:0]            e;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] h;
    logic                    ovf;

    modport master (
        output in_valid, a, b, c, d, e, out_ready,
        input  in_ready, out_valid, h, ovf
    );

    modport slave (
        input  in_valid, a, b, c, d, e, out_ready,
        output in_ready, out_valid, h, ovf
    );
endinterface

// File: rtl/arith_pipe_hs_sat_narrow.sv
// sat_narrow: signed IN_W -> OUT_W narrowing, clamp or wrap.
// in_i: full value; out_o: narrowed; ovf_o: in_i did not fit.
module sat_narrow
    import arith_pipe_pkg::*;
#(
    parameter int IN_W  = 29,
    parameter int OUT_W = 16,
    parameter int SAT   = ARITH_SAT
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o,
    output logic                    ovf_o
);
    localparam logic signed [63:0] MAX64 = s_max(OUT_W);
    localparam logic signed [63:0] MIN64 = s_min(OUT_W);

    // The value fits iff every bit from the OUT_W sign bit
    // upward is a copy of the sign. With IN_W == OUT_W this
    // is a single bit, so ovf_o is constant 0.
    logic [IN_W-OUT_W:0] top;

    assign top   = in_i[IN_W-1:OUT_W-1];
    assign ovf_o = ~((&top) | ~(|top));

    always_comb begin
        out_o = in_i[OUT_W-1:0];
        if (SAT == ARITH_SAT && ovf_o) begin
            if (in_i[IN_W-1]) begin
                out_o = MIN64[OUT_W-1:0];
            end else begin
                out_o = MAX64[OUT_W-1:0];
            end
        end
    end
endmodule

// File: rtl/arith_pipe_hs.sv
// 4-stage pipeline: H = A*E*((A+B)-(C+D)), signed OUT_W result.
// Ports: clk, rst_n, io (operands in / result out), busy.
module arith_pipe_hs
    import arith_pipe_pkg::*;
#(
    parameter int W     = 9,
    parameter int OUT_W = 16,
    parameter int SAT   = ARITH_SAT
) (
    input  logic           clk,
    input  logic           rst_n,
    arith_pipe_hs_if.slave io,
    output logic           busy
);
    localparam int SW = sum_w(W);
    localparam int DW = diff_w(W);
    localparam int GW = 2 * W + 2;
    localparam int PW = prod_w(W);

    logic stall;
    logic accept;

    logic v1_q, v2_q, v3_q, v4_q;

    logic [SW-1:0] x1_q, x1_d;
    logic [SW-1:0] x2_q, x2_d;
    logic [W-1:0]  a1_q, e1_q;
    logic [W-1:0]  a2_q, e2_q;
    logic [W-1:0]  a3_q;

    logic signed [DW-1:0]    f_q, f_d;
    logic signed [GW-1:0]    g_q, g_d;
    logic signed [PW-1:0]    p;
    logic signed [OUT_W-1:0] h_q, h_d;
    logic                    ovf_q, ovf_d;

    // Global stall: the whole pipe freezes, bubbles included.
    assign stall  = v4_q & ~io.out_ready;
    assign accept = io.in_valid & ~stall;

    assign io.in_ready  = ~stall;
    assign io.out_valid = v4_q;
    assign io.h         = h_q;
    assign io.ovf       = ovf_q;
    assign busy         = v1_q | v2_q | v3_q | v4_q;

    always_comb begin
        x1_d = SW'(io.a) + SW'(io.b);
        x2_d = SW'(io.c) + SW'(io.d);
        f_d  = $signed({1'b0, x1_q}) - $signed({1'b0, x2_q});
        // Unsigned e/a are zero-extended, then everything is
        // widened to the product width before multiplying.
        g_d  = GW'($signed({1'b0, e2_q})) * GW'(f_q);
        p    = PW'($signed({1'b0, a3_q})) * PW'(g_q);
    end

    sat_narrow #(
        .IN_W  (PW),
        .OUT_W (OUT_W),
        .SAT   (SAT)
    ) u_narrow (
        .in_i  (p),
        .out_o (h_d),
        .ovf_o (ovf_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            v4_q  <= 1'b0;
            x1_q  <= '0;
            x2_q  <= '0;
            a1_q  <= '0;
            e1_q  <= '0;
            a2_q  <= '0;
            e2_q  <= '0;
            a3_q  <= '0;
            f_q   <= '0;
            g_q   <= '0;
            h_q   <= '0;
            ovf_q <= 1'b0;
        end else if (!stall) begin
            v1_q  <= accept;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            v4_q  <= v3_q;
            x1_q  <= x1_d;
            x2_q  <= x2_d;
            a1_q  <= io.a;
            e1_q  <= io.e;
            a2_q  <= a1_q;
            e2_q  <= e1_q;
            f_q   <= f_d;
            a3_q  <= a2_q;
            g_q   <= g_d;
            h_q   <= h_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: doc/arith_pipe_hs.md
Name: arith_pipe_hs

Overview:
Parametrised 4-stage pipelined arithmetic unit computing H = A * E * ((A+B) - (C+D)) on unsigned W-bit operands.
- Result is signed and OUT_W bits wide.
- Saturating or wrapping narrowing, selected by parameter, with an overflow flag.
- Valid/ready handshake on both sides and full back-pressure stall.
- Successor to the fixed 9-bit, free-running, unsigned-truncating pipeline. It sits between an operand source FIFO and a result sink in the datapath.

Parameters:
W, 9, operand width (unsigned), legal range 2..16.
OUT_W, 16, output result width (signed two's complement), legal range 4..(3*W+2).
SAT, 1, 1 = clamp to the OUT_W signed range on overflow; 0 = keep the low OUT_W bits (wrap).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset; deassertion is synchronised externally.
in_valid  in  1  operand set A..E is valid.
in_ready  out  1  block accepts an operand set this cycle.
a  in  W  operand A, unsigned.
b  in  W  operand B, unsigned.
c  in  W  operand C, unsigned.
d  in  W  operand D, unsigned.
e  in  W  operand E, unsigned.
out_valid  out  1  h and ovf are valid.
out_ready  in  1  sink accepts the result.
h  out  OUT_W  signed result.
ovf  out  1  full-precision result did not fit in OUT_W signed (set regardless of SAT).
busy  out  1  any pipeline stage holds a valid item.

Behaviour:
- Reset: on rst_n low, immediately clear all stage valid bits, h, ovf, out_valid and busy to 0. in_ready = 1 once rst_n is high. Any in-flight data is discarded; nothing is emitted after release.
- Stall: stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
  - While stall: every stage register, including the valid bits, holds its value.
  - No operand is accepted while stalled.
- Accept: an operand set is accepted on a rising edge with in_valid & in_ready.
- Stage 1:
  - x1 = a+b and x2 = c+d, each W+1 bits unsigned.
  - Forward a and e.
- Stage 2:
  - f = x1 - x2, signed W+2 bits.
  - Forward a and e.
- Stage 3:
  - g = e * f, signed 2W+2 bits; e is zero-extended to a signed value.
  - Forward a.
- Stage 4:
  - p = a * g, signed 3W+2 bits; a is zero-extended.
  - Narrow p to OUT_W. ovf = 1 if p > 2^(OUT_W-1)-1 or p < -2^(OUT_W-1).
  - SAT=1 with ovf: h = max or min representable value, by the sign of p.
  - SAT=0: h = p[OUT_W-1:0].
  - When OUT_W = 3W+2, ovf is constant 0.
- Latency: exactly 4 cycles from the accept edge to out_valid high, when no stall occurs. Each stall cycle adds one cycle.
- Throughput: 1 result per cycle while out_ready is held at 1.
- Bubbles: valid bits travel with the data; empty stages do not collapse while stalled (global stall).
- Output stability: while out_valid & ~out_ready, h and ovf are held constant.
- Simultaneous events: accept on the same edge that the output transfers is legal. in_ready does not depend on in_valid.
- No combinational path from in_valid or operands to out_valid or h.
- busy = OR of the four stage valid bits.
- Reset mid-stall: in-flight items are dropped; out_valid = 0 on the next cycle after release.

Decomposition:
- Shared package arith_pipe_pkg:
  - Width helper functions: sum_w(W) = W+1, diff_w(W) = W+2, prod_w(W) = 3W+2.
  - Mode constants ARITH_WRAP = 0 and ARITH_SAT = 1.
  - Signed min/max helpers for OUT_W.
- Sub-module sat_narrow (parameters IN_W, OUT_W, SAT): combinational narrowing plus ovf, instantiated in stage 4. Reused by later DSP blocks.
- The valid chain and stall logic stay inline in arith_pipe_hs.

Test Plan:
1. Defaults (W=9, OUT_W=16, SAT=1), out_ready=1: a=10, b=20, c=5, d=5, e=3 accepted at cycle 0 -> out_valid high in cycle 4 with h=600, ovf=0.
2. Negative difference: a=2, b=0, c=100, d=0, e=4 -> h=-784, ovf=0.
3. Saturation, defaults: a=b=511, c=d=0, e=511 (p=266865662) -> h=32767, ovf=1. Then a=511, b=0, c=d=511, e=511 (p=-133432831) -> h=-32768, ovf=1.
4. Wrap, SAT=0: a=b=511, c=d=0, e=511 -> h=3070, ovf=1. With OUT_W=29 the same vector gives h=266865662, ovf=0.
5. Back-pressure:
   - Stream 8 distinct sets back-to-back and drop out_ready for 3 cycles after the first result.
   - Require: in_ready=0 during the stall, h held, all 8 results in order with none lost or duplicated, busy falls 1 cycle after the last transfer.
6. Reset mid-flight: assert rst_n=0 asynchronously with 3 items in flight -> out_valid, busy, h and ovf go to 0 immediately, and no result appears after release until new input is accepted.
